// File: rtl/fp32_mul_unit.sv
// rtl/fp32_mul_unit.sv - sequential IEEE-754 single multiplier, FTZ + RNE; MUL_RADIX4_EN selects 2 bits/cycle
module fp32_mul_unit #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [EXP_W+FRAC_W:0]   data1_in,
    input  logic [EXP_W+FRAC_W:0]   data2_in,
    input  logic                    trig,
    output logic [EXP_W+FRAC_W:0]   data_out,
    output logic                    vld,
    output logic                    busy
);
    localparam int WW = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;
`ifdef MUL_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int ITERS = MW / STEP;
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [WW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPK, MULT, NORM, RND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t          state_q, state_d;
    special_t        special_q, special_d;
    logic [WW-1:0]   a_q, a_d, b_q, b_d, data_out_q, data_out_d;
    logic            vld_q, vld_d, busy_q, busy_d, sign_q, sign_d;
    logic [XW-1:0]   exp_q, exp_d;
    logic [PW-1:0]   mcand_q, mcand_d, acc_q, acc_d, pp;
    logic [MW-1:0]   mplier_q, mplier_d, sig_q, sig_d;
    logic            guard_q, guard_d, sticky_q, sticky_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [EXP_W-1:0]  ea, eb, rnd_e;
    logic [FRAC_W-1:0] fa, fb, rnd_f;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MW:0]       rnd_sum;
    logic [XW-1:0]     rnd_exp;

    always_comb begin
        ea     = a_q[WW-2:FRAC_W];
        eb     = b_q[WW-2:FRAC_W];
        fa     = a_q[FRAC_W-1:0];
        fb     = b_q[FRAC_W-1:0];
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = !(|ea);
        b_zero = !(|eb);
    end

`ifdef MUL_RADIX4_EN
    always_comb begin
        case (mplier_q[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = mcand_q;
            2'd2:    pp = mcand_q << 1;
            default: pp = mcand_q + (mcand_q << 1);
        endcase
    end
`else
    assign pp = mplier_q[0] ? mcand_q : '0;
`endif

    // A carry out of the rounding add leaves 1.000..0, so the fraction is zero either way.
    always_comb begin
        rnd_sum = {1'b0, sig_q} + (MW+1)'(guard_q & (sticky_q | sig_q[0]));
        rnd_exp = rnd_sum[MW] ? exp_q + XW'(1) : exp_q;
        rnd_f   = rnd_sum[MW] ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];
        rnd_e   = rnd_exp[EXP_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        special_d  = special_q;
        a_d        = a_q;
        b_d        = b_q;
        data_out_d = data_out_q;
        vld_d      = 1'b0;
        busy_d     = busy_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sig_d      = sig_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    a_d     = data1_in;
                    b_d     = data2_in;
                    busy_d  = 1'b1;
                    state_d = UNPK;
                end
            end
            UNPK: begin
                sign_d   = a_q[WW-1] ^ b_q[WW-1];
                exp_d    = {2'b00, ea} + {2'b00, eb} - BIAS;
                mcand_d  = {{MW{1'b0}}, 1'b1, fa};
                mplier_d = {1'b1, fb};
                acc_d    = '0;
                cnt_d    = '0;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                    special_d = SP_NAN;
                else if (a_inf || b_inf)
                    special_d = SP_INF;
                else if (a_zero || b_zero)
                    special_d = SP_ZERO;
                else
                    special_d = SP_NONE;
                state_d = MULT;
            end
            MULT: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1))
                    state_d = NORM;
            end
            NORM: begin
                // Product of two [1,2) significands lies in [1,4): top or next bit is set.
                if (acc_q[PW-1]) begin
                    sig_d    = acc_q[PW-1 -: MW];
                    guard_d  = acc_q[PW-1-MW];
                    sticky_d = |acc_q[PW-2-MW:0];
                    exp_d    = exp_q + XW'(1);
                end else begin
                    sig_d    = acc_q[PW-2 -: MW];
                    guard_d  = acc_q[PW-2-MW];
                    sticky_d = |acc_q[PW-3-MW:0];
                end
                state_d = RND;
            end
            RND: begin
                case (special_q)
                    SP_NAN:  data_out_d = QNAN;
                    SP_INF:  data_out_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    SP_ZERO: data_out_d = {sign_q, {(WW-1){1'b0}}};
                    default: begin
                        if (!rnd_exp[XW-1] && (rnd_exp >= EMAX))
                            data_out_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        else if (rnd_exp[XW-1] || (rnd_exp == '0))
                            data_out_d = {sign_q, {(WW-1){1'b0}}};
                        else
                            data_out_d = {sign_q, rnd_e, rnd_f};
                    end
                endcase
                vld_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            special_q  <= SP_NONE;
            a_q        <= '0;
            b_q        <= '0;
            data_out_q <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            sig_q      <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            special_q  <= special_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_out_q <= data_out_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            sig_q      <= sig_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign vld      = vld_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_fp32_mul_unit.sv
// tb/tb_fp32_mul_unit.sv - directed-vector bench for fp32_mul_unit
module tb_fp32_mul_unit;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] data1_in = '0;
    logic [31:0] data2_in = '0;
    logic        trig = 1'b0;
    logic [31:0] data_out;
    logic        vld;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 27;
`endif

    fp32_mul_unit dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data1_in  (data1_in),
        .data2_in  (data2_in),
        .trig      (trig),
        .data_out  (data_out),
        .vld       (vld),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data1_in = a;
        data2_in = b;
        trig = 1'b1;
        @(posedge sys_clk); #1;
        trig = 1'b0;
    endtask

    task automatic wait_vld(input int start, output int lat);
        lat = start;
        do begin
            @(posedge sys_clk); #1;
            lat++;
        end while (!vld && lat < 80);
    endtask

    task automatic count_vld(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge sys_clk); #1;
            if (vld) pulses++;
        end
    endtask

    logic [31:0] va [12] = '{32'h40000000, 32'hBF800000, 32'h3FC00000, 32'h3F800800,
                             32'h3F800001, 32'h7F000000, 32'h00800000, 32'h80400000,
                             32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h3F800001};
    logic [31:0] vb [12] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800800,
                             32'h3F800001, 32'h7F000000, 32'h00800000, 32'h3F800000,
                             32'h00000000, 32'h40000000, 32'h3F800000, 32'h3FFFFFFF};
    logic [31:0] vr [12] = '{32'h40C00000, 32'hC0000000, 32'h40100000, 32'h3F801000,
                             32'h3F800002, 32'h7F800000, 32'h00000000, 32'h80000000,
                             32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h40000000};

    initial begin
        int lat;
        int pulses;
        repeat (3) @(posedge sys_clk);
        #1;
        expect_eq("reset data_out", data_out, 32'h0);
        expect_eq("reset vld", {31'b0, vld}, 32'h0);
        expect_eq("reset busy", {31'b0, busy}, 32'h0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 12; i++) begin
            start_op(va[i], vb[i]);
            expect_eq($sformatf("busy v%0d", i), {31'b0, busy}, 32'h1);
            wait_vld(0, lat);
            expect_eq($sformatf("latency v%0d", i), lat, LAT);
            expect_eq($sformatf("result v%0d", i), data_out, vr[i]);
            expect_eq($sformatf("busy at vld v%0d", i), {31'b0, busy}, 32'h0);
            @(posedge sys_clk); #1;
            expect_eq($sformatf("vld pulse v%0d", i), {31'b0, vld}, 32'h0);
            expect_eq($sformatf("hold v%0d", i), data_out, vr[i]);
        end

        // trig during busy is dropped; trig in vld cycle starts next op
        start_op(32'h40000000, 32'h40400000);
        repeat (4) begin @(posedge sys_clk); #1; end
        start_op(32'h3FC00000, 32'h3FC00000);
        wait_vld(5, lat);
        expect_eq("ignored trig latency", lat, LAT);
        expect_eq("ignored trig result", data_out, 32'h40C00000);
        start_op(32'hBF800000, 32'h40000000);
        wait_vld(0, lat);
        expect_eq("b2b latency", lat, LAT);
        expect_eq("b2b result", data_out, 32'hC0000000);
        count_vld(40, pulses);
        expect_eq("no extra vld", pulses, 0);

        // reset mid-operation aborts without a vld
        start_op(32'h3FC00000, 32'h3FC00000);
        repeat (9) begin @(posedge sys_clk); #1; end
        sys_rst_n = 1'b0;
        #1;
        expect_eq("abort data_out", data_out, 32'h0);
        expect_eq("abort busy", {31'b0, busy}, 32'h0);
        expect_eq("abort vld", {31'b0, vld}, 32'h0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        count_vld(40, pulses);
        expect_eq("abort no vld", pulses, 0);
        expect_eq("abort data_out held", data_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
